// File: rtl/lamp_display_driver_pkg.sv
// Shared constants and types for the HEX lamp display driver.
package lamp_pkg;

  localparam int NUM_DIGITS_C = 6;
  localparam int SEG_W_C      = 7;
  localparam int LAMP_W_C     = NUM_DIGITS_C * SEG_W_C;

  typedef logic [SEG_W_C-1:0] seg_t;
  typedef seg_t [NUM_DIGITS_C-1:0] lamp_word_t;

  // Pin word with every segment dark for the given pin polarity.
  function automatic lamp_word_t lamp_off(input logic active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/lamp_display_driver_if.sv
// Lamp word in, HEX pins out. The optional lamp_test input exists only when
// LAMP_TEST_EN is defined.
interface lamp_display_driver_if import lamp_pkg::*; #(
  parameter int NUM_DIGITS = NUM_DIGITS_C,
  parameter int SEG_W      = SEG_W_C,
  parameter int PWM_BITS   = 4
);
  logic [NUM_DIGITS*SEG_W-1:0] lamps_in;
  logic [PWM_BITS-1:0]         brightness;
  logic [NUM_DIGITS-1:0]       blink_mask;
`ifdef LAMP_TEST_EN
  logic                        lamp_test;
`endif
  logic [NUM_DIGITS*SEG_W-1:0] hex_out;
  logic                        frame_tick;
  logic                        update_pending;

`ifdef LAMP_TEST_EN
  modport master (output lamps_in, brightness, blink_mask, lamp_test,
                  input  hex_out, frame_tick, update_pending);
  modport slave  (input  lamps_in, brightness, blink_mask, lamp_test,
                  output hex_out, frame_tick, update_pending);
`else
  modport master (output lamps_in, brightness, blink_mask,
                  input  hex_out, frame_tick, update_pending);
  modport slave  (input  lamps_in, brightness, blink_mask,
                  output hex_out, frame_tick, update_pending);
`endif
endinterface

// File: rtl/lamp_display_driver_pwm_gen.sv
// Free-running PWM frame counter: frame boundary pulse and duty-on compare.
module lamp_pwm_gen #(
  parameter int PWM_BITS = 4
) (
  input  logic                gclk,
  input  logic                grst_n,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                frame_tick,
  output logic                duty_on
);

  logic [PWM_BITS-1:0] pwm_cnt;

  // Frame position; wraps naturally at 2**PWM_BITS.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) pwm_cnt <= '0;
    else         pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign frame_tick = (pwm_cnt == '1);
  // All-ones brightness means fully on, including the last frame slot.
  assign duty_on    = (brightness == '1) || (pwm_cnt < brightness);

endmodule

// File: rtl/lamp_display_driver.sv
// Seven-segment lamp driver: frame-synchronous commit of the lamp word,
// global PWM brightness, per-digit blink, registered pin output.
// Optional LAMP_TEST_EN adds a lamp_test input forcing every segment lit.
module lamp_display_driver import lamp_pkg::*; #(
  parameter int NUM_DIGITS = NUM_DIGITS_C,
  parameter int SEG_W      = SEG_W_C,
  parameter int PWM_BITS   = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  lamp_display_driver_if.slave    bus
);

  localparam int LAMP_W = NUM_DIGITS * SEG_W;
  localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [LAMP_W-1:0] OFF_W    = {LAMP_W{ACTIVE_LOW != 0}};

  logic [NUM_DIGITS-1:0][SEG_W-1:0] pend_reg, act_reg, seg_on, seg_drv;
  logic [BLK_W-1:0]  blink_cnt;
  logic              blink_phase;
  logic              frame_tick, duty_on;
  logic [LAMP_W-1:0] hex_reg;

  lamp_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .gclk       (clk_clk),
    .grst_n     (reset_reset_n),
    .brightness (bus.brightness),
    .frame_tick (frame_tick),
    .duty_on    (duty_on)
  );

  // Capture every cycle; only promote to the displayed word at frame end.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pend_reg <= '0;
      act_reg  <= '0;
    end else begin
      pend_reg <= bus.lamps_in;
      if (frame_tick) act_reg <= pend_reg;
    end
  end

  // Blink half-period timer, free-running relative to PWM frames.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    assign seg_on[d] = act_reg[d] &
                       {SEG_W{duty_on & ~(bus.blink_mask[d] & blink_phase)}};
  end

`ifdef LAMP_TEST_EN
  assign seg_drv = bus.lamp_test ? '1 : seg_on;
`else
  assign seg_drv = seg_on;
`endif

  // Pin register; reset leaves every segment dark in the board's polarity.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) hex_reg <= OFF_W;
    else                hex_reg <= (ACTIVE_LOW != 0) ? ~seg_drv : seg_drv;
  end

  assign bus.hex_out        = hex_reg;
  assign bus.frame_tick     = frame_tick;
  assign bus.update_pending = (pend_reg != act_reg);

endmodule
